axis_frame_capture: RTL

- Synthesizable, parametrised AXI4-Stream capture sink for OSPFB output frames. It supersedes the fixed-length bench capture RAM.
- Records FRAMES x FFT_LEN complex samples into on-chip RAM.
- Features: arm/re-arm, programmable frame skip, optional tlast alignment, indexed readout port.
- Sits after the OSPFB/FFT in impulse and tone tops; readout feeds the bench file dump or an AXI-lite bridge.

---
 rtl/alpaca_capture_pkg.sv | 28 ++
 rtl/capture_sdp_ram.sv | 37 +++
 rtl/axis_frame_capture.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alpaca_capture_pkg.sv
// rtl/alpaca_capture_pkg.sv - shared state type, sample type and width helpers for axis_frame_capture
package alpaca_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ALIGN,
        CAPTURE,
        DONE
    } capture_state_t;

    localparam int unsigned CPLX_WIDTH = 16;

    // Matches the {im,re} packing used on the OSPFB/FFT stream buses.
    typedef struct packed {
        logic [CPLX_WIDTH-1:0] im;
        logic [CPLX_WIDTH-1:0] re;
    } cplx_sample_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned frame_idx_width(input int unsigned frames);
        return $clog2(frames) + 1;
    endfunction

endpackage

// File: rtl/capture_sdp_ram.sv
// rtl/capture_sdp_ram.sv - simple dual-port RAM, write port A, registered read-first port B
module capture_sdp_ram #(
    parameter int DEPTH = 2048,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the array gives old data on a same-address collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - AXI4-Stream frame capture sink; AXIS_FRAME_CAPTURE_TLAST_CHECK_EN adds tlast checking
module axis_frame_capture
    import alpaca_capture_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FFT_LEN  = 64,
    parameter int FRAMES   = 32,
    parameter int SKIP_WID = 8,
    parameter int SAMP     = FRAMES * FFT_LEN,
    localparam int AW      = addr_width(SAMP),
    localparam int LW      = addr_width(FFT_LEN),
    localparam int FW      = frame_idx_width(FRAMES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    input  logic                 arm,
    input  logic                 align,
    input  logic [SKIP_WID-1:0]  skip_frames,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_en,
    output logic [2*WIDTH-1:0]   rd_data,
    output logic                 busy,
    output logic                 full,
    output logic [FW-1:0]        frame_cnt
`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    ,
    output logic                 tlast_err,
    output logic [15:0]          tlast_err_cnt
`endif
);

    capture_state_t      r_state;
    capture_state_t      w_state_next;
    logic [AW-1:0]       r_wr_addr;
    logic [FW-1:0]       r_frame_cnt;
    logic [SKIP_WID-1:0] r_skip_cnt;
    logic                r_full;

    logic w_xfer;
    logic w_arm_ok;
    logic w_wr_en;
    logic w_frame_end;
    logic w_last_addr;
    logic w_skip_last;

    assign s_axis_tready = ~rst;
    assign w_xfer        = s_axis_tvalid & s_axis_tready;
    assign w_arm_ok      = arm & ((r_state == IDLE) | (r_state == DONE));
    assign w_wr_en       = (r_state == CAPTURE) & w_xfer;
    assign w_frame_end   = (r_wr_addr[LW-1:0] == LW'(FFT_LEN - 1));
    assign w_last_addr   = (r_wr_addr == AW'(SAMP - 1));
    assign w_skip_last   = (r_skip_cnt == SKIP_WID'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (arm) begin
                    if (skip_frames != '0) begin
                        w_state_next = SKIP;
                    end else if (align) begin
                        w_state_next = ALIGN;
                    end else begin
                        w_state_next = CAPTURE;
                    end
                end
            end
            // The tlast that ends the last skipped frame also satisfies alignment.
            SKIP: begin
                if (w_xfer && s_axis_tlast && w_skip_last) begin
                    w_state_next = CAPTURE;
                end
            end
            ALIGN: begin
                if (w_xfer && s_axis_tlast) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_wr_en && w_last_addr) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr   <= '0;
            r_frame_cnt <= '0;
            r_skip_cnt  <= '0;
            r_full      <= 1'b0;
        end else if (w_arm_ok) begin
            r_wr_addr   <= '0;
            r_frame_cnt <= '0;
            r_skip_cnt  <= skip_frames;
            r_full      <= 1'b0;
        end else begin
            if ((r_state == SKIP) && w_xfer && s_axis_tlast) begin
                r_skip_cnt <= r_skip_cnt - SKIP_WID'(1);
            end
            // Length is counted in beats; tlast never resyncs the write address.
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
                if (w_last_addr) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == SKIP) | (r_state == ALIGN) | (r_state == CAPTURE);
    assign full      = r_full;
    assign frame_cnt = r_frame_cnt;

`ifdef AXIS_FRAME_CAPTURE_TLAST_CHECK_EN
    logic        r_tlast_err;
    logic [15:0] r_tlast_err_cnt;
    logic        w_tlast_bad;

    assign w_tlast_bad = w_wr_en & (s_axis_tlast != w_frame_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tlast_err     <= 1'b0;
            r_tlast_err_cnt <= '0;
        end else if (w_arm_ok) begin
            r_tlast_err     <= 1'b0;
            r_tlast_err_cnt <= '0;
        end else if (w_tlast_bad) begin
            r_tlast_err <= 1'b1;
            if (r_tlast_err_cnt != 16'hFFFF) begin
                r_tlast_err_cnt <= r_tlast_err_cnt + 16'd1;
            end
        end
    end

    assign tlast_err     = r_tlast_err;
    assign tlast_err_cnt = r_tlast_err_cnt;
`endif

    capture_sdp_ram #(
        .DEPTH (SAMP),
        .DW    (2 * WIDTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (s_axis_tdata),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

endmodule
